// File: rtl/pe_stream_sequencer_pkg.sv
// Shared configuration for the PE stream sequencer: FSM state encoding and
// default sizing used by the top level.
package PECfg;
  localparam int NDIM_DEF  = 6;
  localparam int NSTRM_DEF = 2;
  localparam int IDXW_DEF  = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    WORK  = 3'd2,
    STALL = 3'd3,
    DONE  = 3'd4
  } SeqState;
endpackage

// File: rtl/pe_stream_sequencer_lp_nest_counter.sv
// Odometer-style loop nest: dim 0 steps on every inc, higher dims step when
// all lower dims sit on their last index. Size 0 behaves as size 1.
module lp_nest_counter #(
  parameter int NDIM = 6,
  parameter int IDXW = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_inc,
  input  logic [NDIM-1:0][IDXW-1:0]  i_sizes,
  output logic [NDIM-1:0][IDXW-1:0]  o_idx,
  output logic [NDIM-1:0]            o_end
);
  logic [NDIM-1:0] carry;

  always_comb begin
    for (int d = 0; d < NDIM; d++) begin
      if (i_sizes[d] == '0) o_end[d] = (o_idx[d] == '0);
      else                  o_end[d] = (o_idx[d] == i_sizes[d] - IDXW'(1));
    end
  end

  always_comb begin
    logic c;
    c = i_inc;
    for (int d = 0; d < NDIM; d++) begin
      carry[d] = c;
      c = c & o_end[d];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_idx <= '0;
    end else if (i_clear) begin
      o_idx <= '0;
    end else begin
      for (int d = 0; d < NDIM; d++) begin
        if (carry[d]) o_idx[d] <= o_end[d] ? '0 : o_idx[d] + IDXW'(1);
      end
    end
  end
endmodule

// File: rtl/pe_stream_sequencer.sv
// Sequences a loop nest over NSTRM producer scratchpads: accepts producer
// writes, issues consumer reads, and releases entries at each stream's dim.
module pe_stream_sequencer
  import PECfg::*;
#(
  parameter int NDIM  = NDIM_DEF,
  parameter int NSTRM = NSTRM_DEF,
  parameter int IDXW  = IDXW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_start,
  input  logic                                      i_stall,
  input  logic                                      i_sreset,
  input  logic                                      i_dval,
  input  logic [NDIM-1:0][IDXW-1:0]                 i_loop_size,
  input  logic [NSTRM-1:0][$clog2(NDIM)-1:0]        i_rel_dim,
  input  logic [NSTRM-1:0]                          i_src_rdy,
  output logic [NSTRM-1:0]                          o_src_ack,
  output logic                                      o_main_rdy,
  input  logic                                      i_main_ack,
  output logic [NSTRM-1:0][$clog2(DEPTH)-1:0]       o_waddr,
  output logic [NSTRM-1:0][$clog2(DEPTH)-1:0]       o_raddr,
  output logic [NSTRM-1:0]                          o_write,
  output logic                                      o_read,
  output logic [NDIM-1:0][IDXW-1:0]                 o_loop_idx,
  output logic [NDIM-1:0]                           o_loop_end,
  output logic                                      o_busy,
  output logic                                      o_done
);
  localparam int AW = $clog2(DEPTH);

  SeqState state, state_nxt;
  logic finished;
  logic clear;
  logic hs;
  logic last_hs;
  logic [NSTRM-1:0] occ_nz;

  assign o_main_rdy = (state == WORK) && (&occ_nz) && !finished;
  assign hs         = o_main_rdy & i_main_ack;
  assign last_hs    = hs & (&o_loop_end);
  assign o_read     = hs;
  assign clear      = (state_nxt == INIT);
  assign o_busy     = (state == INIT) || (state == WORK) || (state == STALL);
  assign o_done     = (state == DONE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Soft reset outranks completion, which outranks stall.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_dval && i_start) state_nxt = INIT;
      INIT:  if (i_dval) state_nxt = i_sreset ? IDLE : WORK;
      WORK: begin
        if (i_dval && i_sreset)     state_nxt = i_start ? INIT : IDLE;
        else if (last_hs)           state_nxt = DONE;
        else if (i_dval && i_stall) state_nxt = STALL;
      end
      STALL: begin
        if (i_dval && i_sreset)      state_nxt = i_start ? INIT : IDLE;
        else if (i_dval && !i_stall) state_nxt = WORK;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holds the consumer off between the final handshake and leaving WORK.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)       finished <= 1'b0;
    else if (clear)   finished <= 1'b0;
    else if (last_hs) finished <= 1'b1;
  end

  lp_nest_counter #(
    .NDIM (NDIM),
    .IDXW (IDXW)
  ) u_nest (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (clear),
    .i_inc   (hs),
    .i_sizes (i_loop_size),
    .o_idx   (o_loop_idx),
    .o_end   (o_loop_end)
  );

  for (genvar s = 0; s < NSTRM; s++) begin : g_strm
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   occ;
    logic          wr;
    logic          rel;
    logic          rel_ok;

    // An entry is retired once every dim up to the release dim has ended.
    always_comb begin
      rel_ok = 1'b1;
      for (int d = 0; d < NDIM; d++) begin
        if (d <= int'(i_rel_dim[s])) rel_ok = rel_ok & o_loop_end[d];
      end
    end

    assign o_src_ack[s] = (state == WORK) && (occ < (AW+1)'(DEPTH));
    assign wr           = o_src_ack[s] & i_src_rdy[s];
    assign rel          = hs & rel_ok;
    assign o_write[s]   = wr;
    assign o_waddr[s]   = wptr;
    assign o_raddr[s]   = rptr;
    assign occ_nz[s]    = (occ != '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        wptr <= '0;
        rptr <= '0;
        occ  <= '0;
      end else if (clear) begin
        wptr <= '0;
        rptr <= '0;
        occ  <= '0;
      end else begin
        if (wr)  wptr <= wptr + AW'(1);
        if (rel) rptr <= rptr + AW'(1);
        if (wr && !rel)      occ <= occ + (AW+1)'(1);
        else if (!wr && rel) occ <= occ - (AW+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_pe_stream_sequencer.sv
// Directed bench for pe_stream_sequencer with default sizing (6 dims, 2
// streams, 16-entry scratchpads); expected values are worked out by hand.
module tb_pe_stream_sequencer;
  logic              clk;
  logic              rst_n;
  logic              start, stall, sreset, dval;
  logic [5:0][7:0]   loop_size;
  logic [1:0][2:0]   rel_dim;
  logic [1:0]        src_rdy;
  logic [1:0]        src_ack;
  logic              main_rdy;
  logic              main_ack;
  logic [1:0][3:0]   waddr;
  logic [1:0][3:0]   raddr;
  logic [1:0]        wr;
  logic              rd;
  logic [5:0][7:0]   loop_idx;
  logic [5:0]        loop_end;
  logic              busy;
  logic              done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] wq[$];
  logic [3:0] rq[$];
  logic [7:0] i0q[$];
  logic [7:0] i1q[$];
  int         wr1_cnt;

  int e_idx0 [6] = '{0, 1, 0, 1, 0, 1};
  int e_idx1 [6] = '{0, 0, 1, 1, 2, 2};

  int         done_cnt, done_cyc, last_rd_cyc;
  logic [3:0] ra0, ra1, wa0, wa1;
  logic [3:0] diff;

  pe_stream_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_start     (start),
    .i_stall     (stall),
    .i_sreset    (sreset),
    .i_dval      (dval),
    .i_loop_size (loop_size),
    .i_rel_dim   (rel_dim),
    .i_src_rdy   (src_rdy),
    .o_src_ack   (src_ack),
    .o_main_rdy  (main_rdy),
    .i_main_ack  (main_ack),
    .o_waddr     (waddr),
    .o_raddr     (raddr),
    .o_write     (wr),
    .o_read      (rd),
    .o_loop_idx  (loop_idx),
    .o_loop_end  (loop_end),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr[0]) wq.push_back(waddr[0]);
      if (wr[1]) wr1_cnt++;
      if (rd) begin
        rq.push_back(raddr[0]);
        i0q.push_back(loop_idx[0]);
        i1q.push_back(loop_idx[1]);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq.delete(); rq.delete(); i0q.delete(); i1q.delete();
    wr1_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stall = 0; sreset = 0; dval = 0;
    src_rdy = 2'b00; main_ack = 0;
    loop_size = '0;
    loop_size[0] = 8'd2; loop_size[1] = 8'd3;
    loop_size[2] = 8'd1; loop_size[3] = 8'd1; loop_size[4] = 8'd1; loop_size[5] = 8'd1;
    rel_dim[0] = 3'd0; rel_dim[1] = 3'd5;
    clear_mon();
    #2;
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_ack",   32'(src_ack), 32'h0);
    check("rst_mrdy",  32'(main_rdy), 32'h0);
    check("rst_addr",  32'({waddr, raddr}), 32'h0);
    check("rst_idx01", 32'({loop_idx[1], loop_idx[0]}), 32'h0);
    check("rst_end",   32'(loop_end), 32'h3C);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // ---- full run: sizes {2,3,1,1,1,1}, rel_dim {0,5}
    src_rdy = 2'b11; main_ack = 1'b1;
    start = 1'b1; dval = 1'b0;
    tick(1);
    check("dval0_ignored", 32'(busy), 32'h0);
    dval = 1'b1;
    tick(1);
    check("init_busy", 32'(busy), 32'h1);
    check("init_quiet", 32'({src_ack, wr, main_rdy, rd}), 32'h0);
    start = 1'b0;
    tick(1);
    dval = 1'b0;
    clear_mon();
    done_cnt = 0; done_cyc = -1; last_rd_cyc = -1;
    ra0 = 4'hF; ra1 = 4'hF; wa0 = 4'hF; wa1 = 4'hF;
    for (int c = 0; c < 12; c++) begin
      if (rd) last_rd_cyc = c;
      if (done) begin
        done_cnt++; done_cyc = c;
        ra0 = raddr[0]; ra1 = raddr[1]; wa0 = waddr[0]; wa1 = waddr[1];
      end
      tick(1);
    end
    check("a_hs_count", 32'(rq.size()), 32'd6);
    check("a_last_hs_cyc", 32'(last_rd_cyc), 32'd6);
    check("a_done_cyc", 32'(done_cyc), 32'd7);
    check("a_done_cnt", 32'(done_cnt), 32'd1);
    check("a_rel_s0", 32'(ra0), 32'd3);
    check("a_rel_s1", 32'(ra1), 32'd1);
    check("a_wr_s0", 32'(wa0), 32'd7);
    check("a_wr_s1", 32'(wa1), 32'd7);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("a_idx0_%0d", i), (i < i0q.size()) ? 32'(i0q[i]) : 32'hFFFF_FFFF, 32'(e_idx0[i]));
      check($sformatf("a_idx1_%0d", i), (i < i1q.size()) ? 32'(i1q[i]) : 32'hFFFF_FFFF, 32'(e_idx1[i]));
    end
    check("a_idle_busy", 32'({busy, done}), 32'h0);

    // ---- fill, full, release, wrap: sizes {1,100,1,1,1,1}, rel_dim {0,0}
    loop_size[0] = 8'd1; loop_size[1] = 8'd100;
    rel_dim[0] = 3'd0; rel_dim[1] = 3'd0;
    main_ack = 1'b0; src_rdy = 2'b11;
    dval = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    clear_mon();
    tick(1);
    dval = 1'b0;
    tick(20);
    check("b_fill_s0", 32'(wq.size()), 32'd16);
    check("b_fill_s1", 32'(wr1_cnt), 32'd16);
    check("b_full_ack", 32'(src_ack), 32'h0);
    check("b_full_mrdy", 32'(main_rdy), 32'h1);
    check("b_full_waddr", 32'(waddr[0]), 32'h0);
    main_ack = 1'b1;
    #1;
    check("b_full_rel_rd", 32'(rd), 32'h1);
    check("b_full_rel_nowr", 32'({src_ack, wr}), 32'h0);
    tick(1);
    main_ack = 1'b0;
    #1;
    check("b_ack_next", 32'({src_ack, wr}), 32'hF);
    tick(1);
    src_rdy = 2'b00; main_ack = 1'b1;
    tick(8);
    diff = waddr[0] - raddr[0];
    check("b_occ8", 32'(diff), 32'd8);
    src_rdy = 2'b11;
    #1;
    check("b_wr_rel_same", 32'({wr, rd}), 32'h7);
    tick(4);
    diff = waddr[0] - raddr[0];
    check("b_occ8_hold", 32'(diff), 32'd8);
    main_ack = 1'b0;
    tick(12);
    check("b_refill_cnt", 32'(wq.size()), 32'd29);
    check("b_refill_ack", 32'(src_ack), 32'h0);
    src_rdy = 2'b00; main_ack = 1'b1;
    tick(16);
    main_ack = 1'b0;
    check("b_drained", 32'(main_rdy), 32'h0);
    check("b_rd_count", 32'(rq.size()), 32'd29);
    for (int i = 0; i < 20; i++)
      check($sformatf("b_waddr_%0d", i), (i < wq.size()) ? 32'(wq[i]) : 32'hFFFF_FFFF, 32'(i % 16));
    for (int i = 0; i < 29; i++)
      check($sformatf("b_raddr_%0d", i), (i < rq.size()) ? 32'(rq[i]) : 32'hFFFF_FFFF, 32'(i % 16));
    check("b_idx1", 32'(loop_idx[1]), 32'd29);

    // ---- soft reset with restart from WORK
    src_rdy = 2'b11;
    tick(2);
    dval = 1'b1; sreset = 1'b1; start = 1'b1;
    tick(1);
    check("sr_init_busy", 32'(busy), 32'h1);
    check("sr_idx", 32'({loop_idx[1], loop_idx[0]}), 32'h0);
    check("sr_ptrs", 32'({waddr[0], raddr[0]}), 32'h0);
    check("sr_quiet", 32'({src_ack, main_rdy}), 32'h0);
    sreset = 1'b0; start = 1'b0;
    tick(1);
    dval = 1'b0;
    #1;
    check("sr_occ_clear", 32'(main_rdy), 32'h0);
    check("sr_work_ack", 32'(src_ack), 32'h3);

    // ---- stall for 5 cycles mid-run
    main_ack = 1'b1;
    clear_mon();
    tick(5);
    dval = 1'b1; stall = 1'b1;
    tick(1);
    dval = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("st_quiet_%0d", i), 32'({main_rdy, rd, src_ack, wr}), 32'h0);
      check($sformatf("st_idx_%0d", i), 32'(loop_idx[1]), 32'd5);
      if (i == 4) begin
        dval = 1'b1; stall = 1'b0;
      end
      tick(1);
    end
    dval = 1'b0;
    #1;
    check("st_resume_rd", 32'(rd), 32'h1);
    check("st_resume_idx", 32'(loop_idx[1]), 32'd5);
    tick(3);
    check("st_after_idx", 32'(loop_idx[1]), 32'd8);
    check("st_hs_count", 32'(i1q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("st_seq_%0d", i), (i < i1q.size()) ? 32'(i1q[i]) : 32'hFFFF_FFFF, 32'(i));

    // ---- asynchronous reset mid-run
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_ctrl", 32'({busy, done, main_rdy, rd}), 32'h0);
    check("ar_strm", 32'({src_ack, wr}), 32'h0);
    check("ar_ptrs", 32'({waddr, raddr}), 32'h0);
    check("ar_idx", 32'({loop_idx[1], loop_idx[0]}), 32'h0);
    check("ar_end", 32'(loop_end), 32'h3D);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("ar_idle", 32'({busy, src_ack}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
